// File: rtl/adxl_regs_pkg.sv
// Register map, reset values and FSM encoding for the ADXL345-style SPI responder.
package adxl_regs_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] RST_BW_RATE     = 8'h0A;
    localparam logic [7:0] RST_POWER_CTL   = 8'h00;
    localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

    // Upper data byte of a 10-bit sample: sign-extended bits [9:8].
    function automatic logic [7:0] sample_hi(input logic [9:0] s);
        return {{6{s[9]}}, s[9:8]};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one SPI pin with registered rise/fall pulses.
// The level output is aligned with the pulses so data can be sampled on a pulse.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_in,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_sh;
    logic                   sync_q;

    assign sync_q = sync_sh[SYNC_STAGES-1];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_sh <= {SYNC_STAGES{RST_VAL}};
            level   <= RST_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_sh <= {sync_sh[SYNC_STAGES-2:0], din};
            level   <= sync_q;
            rise    <= sync_q & ~level;
            fall    <= ~sync_q & level;
        end
    end

endmodule

// File: rtl/adxl_spi_responder.sv
// SPI mode-3 slave emulating an ADXL345 register file; pins are oversampled on CLK.
// Define ADXL_RESP_MB_EN to honour the multi-byte bit (address auto-increment).
//
// state | meaning
// IDLE  | SS high, waiting for SS fall
// CMD   | shifting in {RW, MB, A[5:0]}
// DATA  | data bytes: MISO out on SCLK fall, MOSI in on SCLK rise
module adxl_spi_responder
    import adxl_regs_pkg::*;
#(
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCLK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] xAxis,
    input  logic [9:0] yAxis,
    input  logic [9:0] zAxis,
    output logic [7:0] power_ctl,
    output logic [7:0] data_format,
    output logic [7:0] bw_rate,
    output logic       wr_strobe,
    output logic [5:0] wr_addr
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk_in(CLK), .rst(RST), .din(SCLK),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_in(CLK), .rst(RST), .din(SS),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_in(CLK), .rst(RST), .din(MOSI),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_state_e state, state_nx;
    logic [2:0] bit_cnt;
    logic [6:0] cmd_sh;
    logic [6:0] rx_sh;
    logic [7:0] tx_sh;
    logic [7:0] rd_data;
    logic [7:0] wr_data;
    logic [5:0] addr;
    logic       rw;
    logic [9:0] snap_x, snap_y, snap_z;
`ifdef ADXL_RESP_MB_EN
    logic       mb;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (ss_fall) state_nx = ST_CMD;
            ST_CMD: begin
                if (ss_rise)                           state_nx = ST_IDLE;
                else if (sclk_rise && bit_cnt == 3'd7) state_nx = ST_DATA;
            end
            ST_DATA: if (ss_rise) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_DEVID:       rd_data = DEVID_VAL;
            ADDR_BW_RATE:     rd_data = bw_rate;
            ADDR_POWER_CTL:   rd_data = power_ctl;
            ADDR_DATA_FORMAT: rd_data = data_format;
            ADDR_DATAX0:      rd_data = snap_x[7:0];
            ADDR_DATAX1:      rd_data = sample_hi(snap_x);
            ADDR_DATAY0:      rd_data = snap_y[7:0];
            ADDR_DATAY1:      rd_data = sample_hi(snap_y);
            ADDR_DATAZ0:      rd_data = snap_z[7:0];
            ADDR_DATAZ1:      rd_data = sample_hi(snap_z);
            default:          rd_data = 8'h00;
        endcase
    end

    assign wr_data = {rx_sh, mosi_lvl};

    always_ff @(posedge CLK) begin
        if (RST) begin
            MISO        <= 1'b0;
            power_ctl   <= RST_POWER_CTL;
            data_format <= RST_DATA_FORMAT;
            bw_rate     <= RST_BW_RATE;
            wr_strobe   <= 1'b0;
            wr_addr     <= 6'h00;
            bit_cnt     <= 3'd0;
            cmd_sh      <= 7'h00;
            rx_sh       <= 7'h00;
            tx_sh       <= 8'h00;
            addr        <= 6'h00;
            rw          <= 1'b0;
            snap_x      <= 10'h000;
            snap_y      <= 10'h000;
            snap_z      <= 10'h000;
`ifdef ADXL_RESP_MB_EN
            mb          <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            if (ss_rise) begin
                MISO <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        MISO <= 1'b0;
                        if (ss_fall) begin
                            snap_x  <= xAxis;
                            snap_y  <= yAxis;
                            snap_z  <= zAxis;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_CMD: begin
                        MISO <= 1'b0;
                        if (sclk_rise) begin
                            cmd_sh  <= {cmd_sh[5:0], mosi_lvl};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw   <= cmd_sh[6];
                                addr <= {cmd_sh[4:0], mosi_lvl};
`ifdef ADXL_RESP_MB_EN
                                mb   <= cmd_sh[5];
`endif
                            end
                        end
                    end
                    ST_DATA: begin
                        // tx is loaded at the first fall of each byte so a byte written
                        // just before is read back with its new value.
                        if (sclk_fall) begin
                            if (bit_cnt == 3'd0) begin
                                tx_sh <= rd_data;
                                MISO  <= rd_data[7];
                            end else begin
                                MISO  <= tx_sh[3'd7 - bit_cnt];
                            end
                        end
                        if (sclk_rise) begin
                            rx_sh   <= {rx_sh[5:0], mosi_lvl};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (!rw) begin
                                    case (addr)
                                        ADDR_BW_RATE:     bw_rate     <= wr_data;
                                        ADDR_POWER_CTL:   power_ctl   <= wr_data;
                                        ADDR_DATA_FORMAT: data_format <= wr_data;
                                        default:          ;
                                    endcase
                                    if (addr == ADDR_BW_RATE || addr == ADDR_POWER_CTL ||
                                        addr == ADDR_DATA_FORMAT) begin
                                        wr_strobe <= 1'b1;
                                        wr_addr   <= addr;
                                    end
                                end
`ifdef ADXL_RESP_MB_EN
                                if (mb) addr <= addr + 6'd1;
`endif
                            end
                        end
                    end
                    default: MISO <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed self-checking bench for adxl_spi_responder (SPI mode 3 master model).
// Expectations follow ADXL_RESP_MB_EN when the bench is built with it defined.
module tb_adxl_spi_responder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SCLK = 1'b1;
    logic       SS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] xAxis = 10'h000;
    logic [9:0] yAxis = 10'h000;
    logic [9:0] zAxis = 10'h000;
    logic [7:0] power_ctl, data_format, bw_rate;
    logic       wr_strobe;
    logic [5:0] wr_addr;

    int vectors = 0;
    int miscompares = 0;
    int strobe_cnt = 0;
    logic [5:0] last_wr_addr = 6'h00;

    adxl_spi_responder dut (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .xAxis(xAxis), .yAxis(yAxis), .zAxis(zAxis),
        .power_ctl(power_ctl), .data_format(data_format), .bw_rate(bw_rate),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (wr_strobe) begin
            strobe_cnt   = strobe_cnt + 1;
            last_wr_addr = wr_addr;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One SCLK cycle: drop SCLK and drive MOSI, sample MISO just before the rise.
    task automatic sclk_bit(input logic b, output logic r);
        SCLK = 1'b0;
        MOSI = b;
        #80;
        r = MISO;
        SCLK = 1'b1;
        #80;
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            sclk_bit(t[i], b);
            r[i] = b;
        end
    endtask

    task automatic ss_start();
        SS = 1'b0;
        #100;
    endtask

    task automatic ss_end();
        #100;
        SS = 1'b1;
        #200;
    endtask

    logic [7:0] rb;
    logic       bit_rb;
    int         strobe_before;
    logic [7:0] exp_burst [6];
    logic [7:0] exp_snap  [4];

    initial begin
`ifdef ADXL_RESP_MB_EN
        exp_burst = '{8'hFF, 8'hFF, 8'h01, 8'h01, 8'h80, 8'h00};
        exp_snap  = '{8'h05, 8'h00, 8'h0A, 8'h00};
`else
        exp_burst = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_snap  = '{8'h05, 8'h05, 8'h0A, 8'h0A};
`endif
        #100;
        RST = 1'b0;
        #50;
        check("rst_miso",        {7'h0, MISO}, 8'h00);
        check("rst_power_ctl",   power_ctl,    8'h00);
        check("rst_data_format", data_format,  8'h00);
        check("rst_bw_rate",     bw_rate,      8'h0A);
        check("rst_wr_strobe",   {7'h0, wr_strobe}, 8'h00);
        check("rst_wr_addr",     {2'b0, wr_addr},   8'h00);

        // DEVID read
        ss_start();
        spi_byte(8'h80, rb);
        check("devid_cmd_miso", rb, 8'h00);
        spi_byte(8'h00, rb);
        check("devid_data", rb, 8'hE5);
        ss_end();
        check("devid_no_strobe", 8'(strobe_cnt), 8'h00);
        check("idle_miso", {7'h0, MISO}, 8'h00);

        // POWER_CTL write
        ss_start();
        spi_byte(8'h2D, rb);
        spi_byte(8'h08, rb);
        ss_end();
        check("pwr_value",       power_ctl,               8'h08);
        check("pwr_strobe_cnt",  8'(strobe_cnt),          8'h01);
        check("pwr_strobe_addr", {2'b0, last_wr_addr},    8'h2D);

        // Burst read of X/Y/Z
        xAxis = 10'h3FF; yAxis = 10'h101; zAxis = 10'h080;
        #50;
        ss_start();
        spi_byte(8'hF2, rb);
        for (int i = 0; i < 6; i++) begin
            spi_byte(8'h00, rb);
            check($sformatf("burst_byte%0d", i), rb, exp_burst[i]);
        end
        ss_end();

        // Snapshot stays frozen for the whole transaction
        xAxis = 10'h005;
        #50;
        ss_start();
        xAxis = 10'h00A;
        spi_byte(8'hF2, rb);
        spi_byte(8'h00, rb);
        check("snap_t1_b0", rb, exp_snap[0]);
        spi_byte(8'h00, rb);
        check("snap_t1_b1", rb, exp_snap[1]);
        ss_end();
        ss_start();
        spi_byte(8'hF2, rb);
        spi_byte(8'h00, rb);
        check("snap_t2_b0", rb, exp_snap[2]);
        spi_byte(8'h00, rb);
        check("snap_t2_b1", rb, exp_snap[3]);
        ss_end();

        // Aborted write to DATA_FORMAT after 5 data bits
        strobe_before = strobe_cnt;
        ss_start();
        spi_byte(8'h31, rb);
        for (int i = 0; i < 5; i++) sclk_bit(1'b1, bit_rb);
        ss_end();
        check("abort_data_format", data_format, 8'h00);
        check("abort_no_strobe",   8'(strobe_cnt - strobe_before), 8'h00);
        ss_start();
        spi_byte(8'hB1, rb);
        spi_byte(8'h00, rb);
        check("abort_readback", rb, 8'h00);
        ss_end();

        // Write to an unmapped address is ignored
        strobe_before = strobe_cnt;
        ss_start();
        spi_byte(8'h10, rb);
        spi_byte(8'h55, rb);
        ss_end();
        check("unmapped_no_strobe", 8'(strobe_cnt - strobe_before), 8'h00);

        // BW_RATE write and read back
        ss_start();
        spi_byte(8'h2C, rb);
        spi_byte(8'h0F, rb);
        ss_end();
        check("bw_value",       bw_rate,              8'h0F);
        check("bw_strobe_addr", {2'b0, last_wr_addr}, 8'h2C);
        ss_start();
        spi_byte(8'hAC, rb);
        spi_byte(8'h00, rb);
        check("bw_readback", rb, 8'h0F);
        ss_end();

        // Reset in the middle of a DATA_FORMAT write
        strobe_before = strobe_cnt;
        ss_start();
        spi_byte(8'h31, rb);
        for (int i = 0; i < 3; i++) sclk_bit(1'b1, bit_rb);
        RST = 1'b1;
        #30;
        check("midrst_power_ctl", power_ctl, 8'h00);
        check("midrst_bw_rate",   bw_rate,   8'h0A);
        check("midrst_miso",      {7'h0, MISO}, 8'h00);
        SS = 1'b1;
        #50;
        RST = 1'b0;
        #200;
        check("midrst_data_format", data_format, 8'h00);
        check("midrst_no_strobe",   8'(strobe_cnt - strobe_before), 8'h00);
        ss_start();
        spi_byte(8'h80, rb);
        spi_byte(8'h00, rb);
        check("post_rst_devid", rb, 8'hE5);
        ss_end();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
